// File: rtl/pcie_acknak_dllp_gen.sv
// Ack/Nak DLLP generator: coalesces Acks, sends Naks with priority, and emits
// each DLLP as a two-beat AXIS frame with the DLLP CRC-16 appended.
module pcie_acknak_dllp_gen #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 3,
    parameter int ACK_LATENCY  = 255,
    parameter int ACK_COALESCE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_active_i,
    input  logic [11:0]           seq_num_i,
    input  logic                  seq_num_vld_i,
    input  logic                  seq_num_acknack_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_tuser_o,
    input  logic                  m_axis_tready_i,
    output logic                  ack_pending_o,
    output logic                  nak_scheduled_o
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("pcie_acknak_dllp_gen supports only DATA_WIDTH = 32");
        end
    endgenerate

    localparam logic [15:0] ACK_LATENCY_C  = 16'(ACK_LATENCY);
    localparam logic [7:0]  ACK_COALESCE_C = 8'(ACK_COALESCE);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t      state, state_next;
    logic [11:0] ack_seq, nak_seq, frame_seq;
    logic        ack_pending, nak_req, nak_scheduled, frame_nak;
    logic [7:0]  ack_cnt, cnt_base, cnt_inc;
    logic [15:0] ack_timer, crc_q;
    logic        launch_nak, launch_ack, launch;
    logic [31:0] launch_word;

    function automatic logic [31:0] beat0_word(input logic is_nak, input logic [11:0] seq);
        return {seq[7:0], 4'h0, seq[11:8], 8'h00, (is_nak ? 8'h10 : 8'h00)};
    endfunction

    // Serial LFSR unrolled over the 32 header bits, byte 0 bit 0 first; the
    // complemented result is bit-reversed within each byte for the wire.
    function automatic logic [15:0] dllp_crc(input logic [31:0] word);
        logic [15:0] c;
        logic [15:0] m;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h100B;
        end
        c = ~c;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            m[8 + j] = c[15 - j];
            m[j]     = c[7 - j];
        end
        return m;
    endfunction

    assign launch_nak  = (state == IDLE) && link_active_i && nak_req;
    assign launch_ack  = (state == IDLE) && link_active_i && !nak_req && ack_pending &&
                         ((ack_timer >= ACK_LATENCY_C) || (ack_cnt >= ACK_COALESCE_C));
    assign launch      = launch_nak || launch_ack;
    assign launch_word = beat0_word(launch_nak, launch_nak ? nak_seq : ack_seq);

    // A strobe landing on the launch cycle counts from zero, after the clear.
    assign cnt_base = launch ? 8'd0 : ack_cnt;
    assign cnt_inc  = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ack_seq       <= '0;
            nak_seq       <= '0;
            frame_seq     <= '0;
            frame_nak     <= 1'b0;
            crc_q         <= '0;
            ack_pending   <= 1'b0;
            ack_cnt       <= '0;
            nak_req       <= 1'b0;
            nak_scheduled <= 1'b0;
            ack_timer     <= '0;
        end else begin
            state <= state_next;

            if (launch) begin
                frame_nak <= launch_nak;
                frame_seq <= launch_nak ? nak_seq : ack_seq;
                crc_q     <= dllp_crc(launch_word);
                ack_timer <= '0;
            end else if (ack_pending && (state == IDLE) && link_active_i &&
                         (ack_timer != 16'hFFFF)) begin
                ack_timer <= ack_timer + 16'd1;
            end

            // A Nak carries the last good seq, so it retires the pending Ack too.
            if (launch) begin
                ack_pending <= 1'b0;
                ack_cnt     <= '0;
            end
            if (launch_nak) nak_req <= 1'b0;

            if (seq_num_vld_i) begin
                if (seq_num_acknack_i) begin
                    ack_seq       <= seq_num_i;
                    ack_pending   <= 1'b1;
                    ack_cnt       <= cnt_inc;
                    nak_scheduled <= 1'b0;
                end else if (!nak_scheduled) begin
                    nak_seq       <= seq_num_i;
                    nak_req       <= 1'b1;
                    nak_scheduled <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = '0;
        m_axis_tkeep_o  = '0;
        m_axis_tlast_o  = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_next = BEAT0;
            end
            BEAT0: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = DATA_WIDTH'(beat0_word(frame_nak, frame_seq));
                m_axis_tkeep_o  = '1;
                if (m_axis_tready_i) state_next = BEAT1;
            end
            BEAT1: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = DATA_WIDTH'({16'h0000, crc_q});
                m_axis_tkeep_o  = KEEP_WIDTH'(4'h3);
                m_axis_tlast_o  = 1'b1;
                if (m_axis_tready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_axis_tuser_o  = '0;
    assign ack_pending_o   = ack_pending;
    assign nak_scheduled_o = nak_scheduled;

endmodule

// File: tb/tb_pcie_acknak_dllp_gen.sv
// Directed bench for pcie_acknak_dllp_gen: coalescing, latency, Nak priority
// and suppression, backpressure, link gating and reset mid-frame.
module tb_pcie_acknak_dllp_gen;

    logic        clk = 1'b0;
    logic        rst, link, vld, acknack, tready;
    logic [11:0] seq;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast;
    logic [2:0]  tuser;
    logic        ack_pending, nak_sched;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcie_acknak_dllp_gen #(
        .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3),
        .ACK_LATENCY(255), .ACK_COALESCE(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .link_active_i(link),
        .seq_num_i(seq), .seq_num_vld_i(vld), .seq_num_acknack_i(acknack),
        .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tvalid_o(tvalid),
        .m_axis_tlast_o(tlast), .m_axis_tuser_o(tuser), .m_axis_tready_i(tready),
        .ack_pending_o(ack_pending), .nak_scheduled_o(nak_sched)
    );

    // Reflected (right-shifting) form of the DLLP CRC, poly 0x100B reversed = 0xD008.
    function automatic logic [15:0] model_crc(input logic [31:0] w);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                if (r[0] ^ w[8*b + k]) r = (r >> 1) ^ 16'hD008;
                else                   r = r >> 1;
        return {~r[7:0], ~r[15:8]};
    endfunction

    task automatic send(input logic [11:0] s, input logic a);
        vld = 1'b1; seq = s; acknack = a;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic capture_frame(input int limit, output bit found, output int cycles,
                                 output logic [31:0] d0, output logic [3:0] k0, output logic l0,
                                 output logic [31:0] d1, output logic [3:0] k1, output logic l1,
                                 output logic v_after);
        cycles = 0; d1 = '0; k1 = '0; l1 = 1'b0; v_after = 1'b0;
        while (!tvalid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        found = tvalid; d0 = tdata; k0 = tkeep; l0 = tlast;
        if (!found) return;
        @(negedge clk);
        d1 = tdata; k1 = tkeep; l1 = tlast;
        @(negedge clk);
        v_after = tvalid;
    endtask

    bit          found;
    int          cyc;
    logic [31:0] d0, d1;
    logic [3:0]  k0, k1;
    logic        l0, l1, va;

    task automatic test_reset();
        rst = 1'b1; link = 1'b1; vld = 1'b0; acknack = 1'b0; seq = '0; tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tuser, ack_pending, nak_sched} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got v=%b d=%h k=%h l=%b u=%h ap=%b ns=%b want all 0",
                     tvalid, tdata, tkeep, tlast, tuser, ack_pending, nak_sched);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle got tvalid=%b want 0", tvalid);
        end
    endtask

    task automatic test_coalesce();
        send(12'd0, 1'b1); send(12'd1, 1'b1); send(12'd2, 1'b1); send(12'd3, 1'b1);
        checks++;
        if ({ack_pending, tvalid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL coalesce_pending got ap=%b v=%b want ap=1 v=0", ack_pending, tvalid);
        end
        @(negedge clk);
        checks++;
        if ({ack_pending, tvalid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL coalesce_launch got ap=%b v=%b want ap=0 v=1", ack_pending, tvalid);
        end
        capture_frame(2, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if ({found, d0, k0, l0} !== {1'b1, 32'h03000000, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL coalesce_beat0 got d=%h k=%h l=%b want d=03000000 k=f l=0", d0, k0, l0);
        end
        checks++;
        if ({d1, k1, l1, va} !== {16'h0, model_crc(32'h03000000), 4'h3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL coalesce_beat1 got d=%h k=%h l=%b v_after=%b want d=%h k=3 l=1 v_after=0",
                     d1, k1, l1, va, {16'h0, model_crc(32'h03000000)});
        end
    endtask

    task automatic test_latency();
        send(12'hABC, 1'b1);
        capture_frame(400, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if (!found || cyc < 256 || cyc > 257) begin
            errors++;
            $display("[TB] FAIL latency_time got found=%b cycles=%0d want 256..257", found, cyc);
        end
        checks++;
        if (d0 !== 32'hBC0A0000) begin
            errors++;
            $display("[TB] FAIL latency_beat0 got %h want bc0a0000", d0);
        end
        checks++;
        if ({d1, k1, l1} !== {16'h0, model_crc(32'hBC0A0000), 4'h3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL latency_beat1 got d=%h k=%h l=%b want d=%h k=3 l=1",
                     d1, k1, l1, {16'h0, model_crc(32'hBC0A0000)});
        end
    endtask

    task automatic test_nak_priority();
        send(12'd5, 1'b1);
        send(12'd6, 1'b0);
        capture_frame(10, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if (!found || cyc > 1 || d0 !== 32'h06000010) begin
            errors++;
            $display("[TB] FAIL nak_priority_beat0 got found=%b cycles=%0d d=%h want cycles<=1 d=06000010",
                     found, cyc, d0);
        end
        checks++;
        if (d1 !== {16'h0, model_crc(32'h06000010)}) begin
            errors++;
            $display("[TB] FAIL nak_priority_crc got %h want %h", d1, {16'h0, model_crc(32'h06000010)});
        end
        checks++;
        if ({ack_pending, nak_sched} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL nak_priority_flags got ap=%b ns=%b want ap=0 ns=1", ack_pending, nak_sched);
        end
    endtask

    task automatic test_nak_suppression();
        bit seen;
        send(12'd7, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tvalid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || nak_sched !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nak_suppress got frame_seen=%b ns=%b want 0/1", seen, nak_sched);
        end
        send(12'd8, 1'b1);
        checks++;
        if ({nak_sched, ack_pending} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL nak_clear got ns=%b ap=%b want ns=0 ap=1", nak_sched, ack_pending);
        end
        send(12'd9, 1'b0);
        capture_frame(10, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if ({found, d0, d1} !== {1'b1, 32'h09000010, 16'h0, model_crc(32'h09000010)}) begin
            errors++;
            $display("[TB] FAIL nak_resend got found=%b d0=%h d1=%h want d0=09000010 d1=%h",
                     found, d0, d1, {16'h0, model_crc(32'h09000010)});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp0, exp1;
        bit          phase, done, hs;
        int          w;
        exp0 = 32'h13000000;
        exp1 = {16'h0, model_crc(exp0)};
        tready = 1'b0;
        send(12'h010, 1'b1); send(12'h011, 1'b1); send(12'h012, 1'b1); send(12'h013, 1'b1);
        w = 0;
        while (!tvalid && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({tvalid, tdata, tkeep, tlast} !== {1'b1, exp0, 4'hF, 1'b0}) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got v=%b d=%h k=%h l=%b want v=1 d=%h k=f l=0",
                         i, tvalid, tdata, tkeep, tlast, exp0);
            end
            if (i == 3) begin
                vld = 1'b1; seq = 12'h020; acknack = 1'b1;
            end else begin
                vld = 1'b0;
            end
            @(negedge clk);
        end
        phase = 1'b0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            checks++;
            if (!phase && {tvalid, tdata, tkeep, tlast} !== {1'b1, exp0, 4'hF, 1'b0}) begin
                errors++;
                $display("[TB] FAIL bp_toggle_beat0[%0d] got v=%b d=%h k=%h l=%b", k, tvalid, tdata, tkeep, tlast);
            end else if (phase && {tvalid, tdata, tkeep, tlast} !== {1'b1, exp1, 4'h3, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bp_toggle_beat1[%0d] got v=%b d=%h k=%h l=%b want d=%h",
                         k, tvalid, tdata, tkeep, tlast, exp1);
            end
            tready = (k % 2 == 1);
            hs = tvalid && tready;
            @(negedge clk);
            if (hs) begin
                if (phase) done = 1'b1;
                else       phase = 1'b1;
            end
        end
        checks++;
        if (!done || tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_complete got done=%b tvalid=%b want 1/0", done, tvalid);
        end
        tready = 1'b1;
        capture_frame(400, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if ({found, d0, d1} !== {1'b1, 32'h20000000, 16'h0, model_crc(32'h20000000)}) begin
            errors++;
            $display("[TB] FAIL bp_second_frame got found=%b d0=%h d1=%h want d0=20000000",
                     found, d0, d1);
        end
    endtask

    task automatic test_link();
        bit seen;
        int w;
        tready = 1'b0;
        send(12'h050, 1'b1); send(12'h051, 1'b1); send(12'h052, 1'b1); send(12'h053, 1'b1);
        w = 0;
        while (!tvalid && w < 10) begin
            @(negedge clk);
            w++;
        end
        link = 1'b0;
        tready = 1'b1;
        capture_frame(0, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if ({found, d0, d1, l1, va} !== {1'b1, 32'h53000000, 16'h0, model_crc(32'h53000000), 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL link_drop_midframe got found=%b d0=%h d1=%h l=%b v_after=%b",
                     found, d0, d1, l1, va);
        end
        send(12'h030, 1'b1); send(12'h031, 1'b1); send(12'h032, 1'b1); send(12'h033, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tvalid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || ack_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL link_hold got frame_seen=%b ap=%b want 0/1", seen, ack_pending);
        end
        link = 1'b1;
        capture_frame(5, found, cyc, d0, k0, l0, d1, k1, l1, va);
        checks++;
        if ({found, d0} !== {1'b1, 32'h33000000} || cyc != 1) begin
            errors++;
            $display("[TB] FAIL link_resume got found=%b cycles=%0d d0=%h want cycles=1 d0=33000000",
                     found, cyc, d0);
        end
    endtask

    task automatic test_reset_midframe();
        bit seen;
        int w;
        tready = 1'b0;
        send(12'h040, 1'b1); send(12'h041, 1'b1); send(12'h042, 1'b1); send(12'h043, 1'b1);
        w = 0;
        while (!tvalid && w < 10) begin
            @(negedge clk);
            w++;
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if ({tvalid, tlast} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rst_mid_beat1 got v=%b l=%b want 1/1", tvalid, tlast);
        end
        tready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tuser, ack_pending, nak_sched} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs got v=%b d=%h k=%h l=%b u=%h ap=%b ns=%b want all 0",
                     tvalid, tdata, tkeep, tlast, tuser, ack_pending, nak_sched);
        end
        rst = 1'b0;
        tready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tvalid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL rst_mid_quiet got frame_seen=%b want 0", seen);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_coalesce();
        test_latency();
        test_nak_priority();
        test_nak_suppression();
        test_backpressure();
        test_link();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
